// File: rtl/lp_grid_solver.sv
`default_nettype none
// ============================================================================
// Module   : lp_grid_solver
// Purpose  : Two-variable integer LP solved by brute-force scan of the box
//            grid, LANES consecutive x1 points evaluated per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module lp_grid_solver #(
    parameter int NCON  = 6,
    parameter int CW    = 6,
    parameter int BW    = 12,
    parameter int LANES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_mode,
    input  logic signed [CW-1:0]    in_a1,
    input  logic signed [CW-1:0]    in_a2,
    input  logic signed [BW-1:0]    in_b,
    output logic                    out_valid,
    output logic signed [CW+BW+1:0] out_value,
    output logic signed [BW-1:0]    out_x1,
    output logic signed [BW-1:0]    out_x2,
    output logic [1:0]              out_status
);
    localparam int VW  = CW + BW + 2;
    localparam int XW  = BW + 2;
    localparam int BCW = $clog2(NCON + 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOAD = 2'd1;
    localparam logic [1:0] c_SCAN = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam logic [1:0] c_ST_OPT    = 2'b00;
    localparam logic [1:0] c_ST_INFEAS = 2'b01;
    localparam logic [1:0] c_ST_BADBOX = 2'b10;

    localparam logic [BCW-1:0]       c_LAST_BEAT = BCW'(NCON);
    localparam logic [BCW-1:0]       c_BEAT_ONE  = BCW'(1);
    localparam logic signed [CW-1:0] c_POS_ONE   = CW'(1);
    localparam logic signed [CW-1:0] c_NEG_ONE   = '1;
    localparam logic signed [XW-1:0] c_X_ONE     = XW'(1);
    localparam logic signed [XW-1:0] c_X_LANES   = XW'(LANES);

    logic [1:0]              r_state;
    logic [1:0]              w_next_state;
    logic [BCW-1:0]          r_beat;
    logic                    r_mode;
    logic signed [CW-1:0]    r_c1, r_c2;
    logic signed [CW-1:0]    r_a1 [NCON];
    logic signed [CW-1:0]    r_a2 [NCON];
    logic signed [BW-1:0]    r_b  [NCON];
    logic [3:0]              r_seen, w_seen;
    logic signed [XW-1:0]    r_x1max, r_x1min, r_x2max, r_x2min;
    logic signed [XW-1:0]    w_x1max, w_x1min, w_x2max, w_x2min;
    logic signed [XW-1:0]    r_x1, r_x2;
    logic                    r_have;
    logic signed [VW-1:0]    r_best_val;
    logic signed [BW-1:0]    r_best_x1, r_best_x2;
    logic signed [VW-1:0]    r_out_value;
    logic signed [BW-1:0]    r_out_x1, r_out_x2;
    logic [1:0]              r_out_status;

    logic                    w_accept, w_last_beat, w_bad;
    logic signed [XW-1:0]    w_b_x, w_next_x1;
    logic                    w_row_end, w_scan_end;
    logic signed [VW-1:0]    w_a1e [NCON];
    logic signed [VW-1:0]    w_a2e [NCON];
    logic signed [VW-1:0]    w_be  [NCON];
    logic signed [VW-1:0]    w_c1e, w_c2e, w_x1e, w_x2e, w_x1maxe;
    logic [LANES-1:0]        w_feas;
    logic signed [VW-1:0]    w_obj [LANES];
    logic signed [BW-1:0]    w_lx1 [LANES];
    logic                    w_nb_have;
    logic signed [VW-1:0]    w_nb_val;
    logic signed [BW-1:0]    w_nb_x1, w_nb_x2;

    assign w_accept    = in_valid && in_ready;
    assign w_last_beat = w_accept && (r_state == c_LOAD) && (r_beat == c_LAST_BEAT);
    assign w_b_x       = {{(XW-BW){in_b[BW-1]}}, in_b};

    // Box bounds including the beat being accepted, so the final beat's box
    // form is visible to the BAD_BOX decision and the scan start point.
    always_comb begin
        w_x1max = r_x1max;
        w_x1min = r_x1min;
        w_x2max = r_x2max;
        w_x2min = r_x2min;
        w_seen  = r_seen;
        if (w_accept && (r_state == c_LOAD)) begin
            if (in_a1 == c_POS_ONE && in_a2 == '0) begin
                w_x1max   = w_b_x;
                w_seen[0] = 1'b1;
            end
            if (in_a1 == c_NEG_ONE && in_a2 == '0) begin
                w_x1min   = -w_b_x;
                w_seen[1] = 1'b1;
            end
            if (in_a1 == '0 && in_a2 == c_POS_ONE) begin
                w_x2max   = w_b_x;
                w_seen[2] = 1'b1;
            end
            if (in_a1 == '0 && in_a2 == c_NEG_ONE) begin
                w_x2min   = -w_b_x;
                w_seen[3] = 1'b1;
            end
        end
    end

    assign w_bad = (w_seen != 4'hF) || (w_x1max < w_x1min) || (w_x2max < w_x2min);

    assign w_next_x1  = r_x1 + c_X_LANES;
    assign w_row_end  = (w_next_x1 > r_x1max);
    assign w_scan_end = w_row_end && (r_x2 == r_x2max);

    assign w_c1e    = {{(VW-CW){r_c1[CW-1]}}, r_c1};
    assign w_c2e    = {{(VW-CW){r_c2[CW-1]}}, r_c2};
    assign w_x1e    = {{(VW-XW){r_x1[XW-1]}}, r_x1};
    assign w_x2e    = {{(VW-XW){r_x2[XW-1]}}, r_x2};
    assign w_x1maxe = {{(VW-XW){r_x1max[XW-1]}}, r_x1max};

    for (genvar k = 0; k < NCON; k++) begin : g_con
        assign w_a1e[k] = {{(VW-CW){r_a1[k][CW-1]}}, r_a1[k]};
        assign w_a2e[k] = {{(VW-CW){r_a2[k][CW-1]}}, r_a2[k]};
        assign w_be[k]  = {{(VW-BW){r_b[k][BW-1]}}, r_b[k]};
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        localparam logic signed [VW-1:0] c_OFF = VW'(l);
        logic signed [VW-1:0] w_px1;
        logic                 w_ok;

        assign w_px1 = w_x1e + c_OFF;

        always_comb begin
            w_ok = (w_px1 <= w_x1maxe);
            for (int k = 0; k < NCON; k++) begin
                if (w_a1e[k] * w_px1 + w_a2e[k] * w_x2e > w_be[k]) begin
                    w_ok = 1'b0;
                end
            end
        end

        assign w_feas[l] = w_ok;
        assign w_obj[l]  = w_c1e * w_px1 + w_c2e * w_x2e;
        assign w_lx1[l]  = w_px1[BW-1:0];
    end

    // Incumbent is offered first, then lanes in ascending order: strict
    // improvement only, so ties keep the earliest point in scan order.
    always_comb begin
        w_nb_have = r_have;
        w_nb_val  = r_best_val;
        w_nb_x1   = r_best_x1;
        w_nb_x2   = r_best_x2;
        for (int l = 0; l < LANES; l++) begin
            if (w_feas[l] && (!w_nb_have ||
                (r_mode ? (w_obj[l] < w_nb_val) : (w_obj[l] > w_nb_val)))) begin
                w_nb_have = 1'b1;
                w_nb_val  = w_obj[l];
                w_nb_x1   = w_lx1[l];
                w_nb_x2   = r_x2[BW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_accept) w_next_state = c_LOAD;
            c_LOAD:  if (w_last_beat) w_next_state = w_bad ? c_DONE : c_SCAN;
            c_SCAN:  if (w_scan_end) w_next_state = c_DONE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == c_IDLE) || (r_state == c_LOAD);
        out_valid = (r_state == c_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat       <= '0;
            r_mode       <= 1'b0;
            r_c1         <= '0;
            r_c2         <= '0;
            r_seen       <= '0;
            r_x1max      <= '0;
            r_x1min      <= '0;
            r_x2max      <= '0;
            r_x2min      <= '0;
            r_x1         <= '0;
            r_x2         <= '0;
            r_have       <= 1'b0;
            r_best_val   <= '0;
            r_best_x1    <= '0;
            r_best_x2    <= '0;
            r_out_value  <= '0;
            r_out_x1     <= '0;
            r_out_x2     <= '0;
            r_out_status <= '0;
            for (int k = 0; k < NCON; k++) begin
                r_a1[k] <= '0;
                r_a2[k] <= '0;
                r_b[k]  <= '0;
            end
        end else begin
            r_x1max <= w_x1max;
            r_x1min <= w_x1min;
            r_x2max <= w_x2max;
            r_x2min <= w_x2min;
            r_seen  <= w_seen;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_mode <= in_mode;
                        r_c1   <= in_a1;
                        r_c2   <= in_a2;
                        r_beat <= c_BEAT_ONE;
                        r_seen <= '0;
                        r_have <= 1'b0;
                    end
                end
                c_LOAD: begin
                    if (w_accept) begin
                        for (int k = 0; k < NCON; k++) begin
                            if (r_beat == BCW'(k + 1)) begin
                                r_a1[k] <= in_a1;
                                r_a2[k] <= in_a2;
                                r_b[k]  <= in_b;
                            end
                        end
                        r_beat <= r_beat + c_BEAT_ONE;
                        if (r_beat == c_LAST_BEAT) begin
                            r_beat <= '0;
                            r_x1   <= w_x1min;
                            r_x2   <= w_x2min;
                            if (w_bad) begin
                                r_out_status <= c_ST_BADBOX;
                                r_out_value  <= '0;
                                r_out_x1     <= '0;
                                r_out_x2     <= '0;
                            end
                        end
                    end
                end
                c_SCAN: begin
                    r_have     <= w_nb_have;
                    r_best_val <= w_nb_val;
                    r_best_x1  <= w_nb_x1;
                    r_best_x2  <= w_nb_x2;
                    if (w_row_end) begin
                        r_x1 <= r_x1min;
                        r_x2 <= r_x2 + c_X_ONE;
                    end else begin
                        r_x1 <= w_next_x1;
                    end
                    if (w_scan_end) begin
                        r_out_status <= w_nb_have ? c_ST_OPT : c_ST_INFEAS;
                        r_out_value  <= w_nb_have ? w_nb_val : '0;
                        r_out_x1     <= w_nb_have ? w_nb_x1 : '0;
                        r_out_x2     <= w_nb_have ? w_nb_x2 : '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_value  = r_out_value;
    assign out_x1     = r_out_x1;
    assign out_x2     = r_out_x2;
    assign out_status = r_out_status;

endmodule
`default_nettype wire

// File: doc/lp_grid_solver.md
# lp_grid_solver

Parametrised successor to the team's two-variable integer LP block. It streams in an objective and `NCON` linear constraints, then brute-force scans the integer grid bounded by the box constraints. `LANES` grid points are evaluated per cycle. It reports the optimum (max or min mode), its arg-optimum point, and a status code. The block sits behind the problem-loader stream and drives one result beat to the result collector.

## Interface
- `NCON`, 6: constraints per problem (≥4; includes the four box constraints).
- `CW`, 6: signed coefficient width (`a1`, `a2`, `c1`, `c2`).
- `BW`, 12: signed bound width (`b`, grid coordinates).
- `LANES`, 1: consecutive x1 points evaluated per cycle (power of 2, 1..8).
- `clk` in 1: clock; everything is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input beat valid; accepted only when `in_ready`=1.
- `in_ready` out 1: high in IDLE and LOAD; low in SCAN and DONE.
- `in_mode` in 1: sampled on beat 0; 0 = maximise, 1 = minimise.
- `in_a1`, `in_a2` in CW: beat 0 carries `c1`/`c2`; beats 1..NCON carry constraint coefficients.
- `in_b` in BW: constraint bound for beats 1..NCON; ignored on beat 0.
- `out_valid` out 1: single-cycle result strobe.
- `out_value` out CW+BW+2: optimal objective, signed.
- `out_x1`, `out_x2` out BW: arg-optimum point, signed.
- `out_status` out 2: 00 OPTIMAL, 01 INFEASIBLE, 10 BAD_BOX, 11 reserved.

## Operation
- **Reset values:** all outputs 0 except `in_ready`=1; state IDLE; beat counter 0.
- **States and transitions:**
  - IDLE→LOAD on the first accepted beat (beat 0).
  - LOAD stays until beat NCON is accepted. Gaps in `in_valid` are allowed and stall the beat counter.
  - After the last beat:
    - BAD_BOX if any box constraint was not seen, or if x1max<x1min or x2max<x2min. Goes straight to DONE.
    - Otherwise SCAN.
  - SCAN→DONE after the final grid row.
  - DONE→IDLE after one cycle.
- **Box detection:** the four box constraints are recognised by their coefficients.
  - (1,0,b) sets x1max=b; (−1,0,b) sets x1min=−b.
  - (0,1,b) sets x2max=b; (0,−1,b) sets x2min=−b.
  - If a form repeats, the last occurrence wins.
  - Box constraints are also stored and checked like any other constraint.
- **Scan order:** x2 outer, ascending from x2min. x1 inner, ascending from x1min in groups of `LANES`.
  - Lanes beyond x1max in the last group of a row are masked, never feasible.
  - Rows restart at x1min.
- **Feasibility:** a point is feasible when a1·x1 + a2·x2 ≤ b holds for all NCON stored constraints.
  - Evaluate at width CW+BW+2 signed, sign-extended, with no saturation or wrap.
  - Objective c1·x1 + c2·x2 uses the same width.
- **Update rule:** the incumbent is replaced only by a strictly better value (> in max mode, < in min mode).
  - Ties keep the earliest point in scan order; within a group, the lower lane wins.
  - The first feasible point is always taken.
- **Result:**
  - OPTIMAL: at least one feasible point found; `out_value`, `out_x1`, `out_x2` hold the incumbent.
  - INFEASIBLE: no feasible point; value and point outputs are 0.
  - BAD_BOX: value and point outputs are 0.
- Outputs hold their values after `out_valid` drops, until the next result.

## Timing
- Let t be the cycle in which beat NCON is accepted.
- SCAN occupies cycles t+1 .. t+S, with S = (x2max−x2min+1)·ceil((x1max−x1min+1)/LANES).
- `out_valid`=1 in cycle t+S+1 (DONE). `in_ready` returns high at t+S+2.
- For BAD_BOX, `out_valid` is at t+1.
- Back-to-back problems: beat 0 of the next problem may be accepted in the first cycle `in_ready`=1.
- `rst` asserted in any state: next cycle is IDLE with reset values. Any partial load or scan is discarded; no `out_valid` is produced for the aborted problem.
- `in_valid` while `in_ready`=0 is ignored and not buffered.

## Test plan
- **Max mode, NCON=6, LANES=1:**
  - Stimulus: c=(1,1); constraints x1≤3, −x1≤0, x2≤3, −x2≤0, x1+x2≤4, x1−x2≤1.
  - Response: OPTIMAL, value 4 at (2,2); `out_valid` at t+17.
- **Same problem, min mode:** OPTIMAL, value 0 at (0,0), t+17.
- **Same problem, LANES=4:** identical result at t+5. Also x1max=4 with LANES=4: masked lanes are not selected and S=8.
- **Infeasible:** replace x1+x2≤4 with x1+x2≤−1 → INFEASIBLE, value 0, point (0,0).
- **BAD_BOX:**
  - Replace −x2≤0 with (1,1)≤4 → status 10 at t+1.
  - x1 box 5≤x1≤3 → status 10.
- **Reset and gaps:**
  - Assert `rst` in the 5th SCAN cycle → no `out_valid`, `in_ready`=1 next cycle; a fresh problem then completes normally.
  - LOAD with 2-cycle `in_valid` gaps → same result as the contiguous load.
